// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: operation encodings, the
// mul/div sequencer states and the EX/MEM register layout with its reset value.
package ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MFHI  = 3'd5,
    MD_MFLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        overflow;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
  } exm_t;

  localparam exm_t EXM_RST = '0;

  // True for the operations that occupy the iterative unit.
  function automatic logic is_muldiv(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_mul_div.sv
// Iterative multiply/divide unit with HI/LO. 32 shift-add or restoring-subtract
// steps on operand magnitudes; signs are reapplied when HI/LO are written.
module mul_div_unit
  import ex_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_i,
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e   state_q;
  logic [4:0]  cnt_q;
  logic [31:0] acc_q;      // multiply: running high half; divide: partial remainder
  logic [31:0] mq_q;       // multiply: multiplier shifting out; divide: dividend/quotient
  logic [31:0] bmag_q;     // multiplicand or divisor magnitude
  logic        is_div_q;
  logic        neg_q;      // operand signs differed on a signed op
  logic        rem_neg_q;  // signed dividend was negative
  logic        div0_q;
  logic [31:0] hi_q, lo_q;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [31:0] acc_nx, mq_nx;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, hi_nx, lo_nx;

  // Operand magnitudes and sign bookkeeping captured at start.
  always_comb begin
    signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    a_neg     = signed_op & a_i[31];
    b_neg     = signed_op & b_i[31];
    a_mag     = a_neg ? (32'd0 - a_i) : a_i;
    b_mag     = b_neg ? (32'd0 - b_i) : b_i;
  end

  // One iteration step plus the sign-corrected HI/LO values of the final step.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, bmag_q} : 33'd0);
    rem_sh  = {acc_q, mq_q[31]};
    div_ge  = rem_sh >= {1'b0, bmag_q};
    div_sub = rem_sh[31:0] - bmag_q;
    if (is_div_q) begin
      acc_nx = div_ge ? div_sub : rem_sh[31:0];
      mq_nx  = {mq_q[30:0], div_ge};
    end else begin
      acc_nx = mul_sum[32:1];
      mq_nx  = {mul_sum[0], mq_q[31:1]};
    end
    prod_fix = neg_q ? (64'd0 - {acc_nx, mq_nx}) : {acc_nx, mq_nx};
    quo_fix  = div0_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - mq_nx) : mq_nx);
    rem_fix  = rem_neg_q ? (32'd0 - acc_nx) : acc_nx;
    hi_nx    = is_div_q ? rem_fix : prod_fix[63:32];
    lo_nx    = is_div_q ? quo_fix : prod_fix[31:0];
  end

  // Sequencer IDLE -> RUN (32 steps) -> DONE -> IDLE, writing HI/LO on the last step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      bmag_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            acc_q     <= '0;
            mq_q      <= a_mag;
            bmag_q    <= b_mag;
            is_div_q  <= (op_i == MD_DIV) || (op_i == MD_DIVU);
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= (b_i == 32'd0);
            cnt_q     <= '0;
            state_q   <= MD_RUN;
          end
        end
        MD_RUN: begin
          acc_q <= acc_nx;
          mq_q  <= mq_nx;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_q    <= hi_nx;
            lo_q    <= lo_nx;
            state_q <= MD_DONE;
          end
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == MD_RUN);
  assign done_o = (state_q == MD_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, MEM/WB forwarding, ALU, EX/MEM register
// and the stall generated while the multiply/divide unit is busy.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [31:0] id_reg_a,
  input  logic [31:0] id_reg_b,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_alu_op,
  input  logic [2:0]  id_md_op,
  input  logic        id_use_imm,
  input  logic        id_dest_rt,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        mem_reg_write,
  input  logic        wb_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,
  output logic        stall,
  output logic        exm_valid,
  output logic        exm_reg_write,
  output logic        exm_mem_read,
  output logic        exm_mem_write,
  output logic        exm_overflow,
  output logic [31:0] exm_result,
  output logic [31:0] exm_store_data,
  output logic [4:0]  exm_rd
);

  // ID/EX control (reset to a bubble) and data (no reset needed)
  logic        idex_valid_q, idex_use_imm_q, idex_dest_rt_q;
  logic        idex_reg_write_q, idex_mem_read_q, idex_mem_write_q;
  alu_op_e     idex_alu_op_q;
  md_op_e      idex_md_op_q;
  logic [31:0] idex_reg_a_q, idex_reg_b_q, idex_imm_q;
  logic [4:0]  idex_rs_q, idex_rt_q, idex_rd_q;

  logic [31:0] fwd_rs, fwd_rt, op_b, sum, dif, alu_res;
  logic [4:0]  shamt;
  logic        alu_ovf;
  logic        md_slot, md_start, md_busy, md_done;
  logic [31:0] hi, lo;
  exm_t        exm_d, exm_q;

  // ID/EX control fields: load when not stalled, cleared to a bubble on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idex_valid_q     <= 1'b0;
      idex_use_imm_q   <= 1'b0;
      idex_dest_rt_q   <= 1'b0;
      idex_reg_write_q <= 1'b0;
      idex_mem_read_q  <= 1'b0;
      idex_mem_write_q <= 1'b0;
      idex_alu_op_q    <= ALU_ADD;
      idex_md_op_q     <= MD_NONE;
    end else if (!stall) begin
      idex_valid_q     <= id_valid;
      idex_use_imm_q   <= id_use_imm;
      idex_dest_rt_q   <= id_dest_rt;
      idex_reg_write_q <= id_reg_write;
      idex_mem_read_q  <= id_mem_read;
      idex_mem_write_q <= id_mem_write;
      idex_alu_op_q    <= alu_op_e'(id_alu_op);
      idex_md_op_q     <= md_op_e'(id_md_op);
    end
  end

  // ID/EX datapath fields follow the same hold rule.
  always_ff @(posedge clock) begin
    if (!stall) begin
      idex_reg_a_q <= id_reg_a;
      idex_reg_b_q <= id_reg_b;
      idex_imm_q   <= id_imm;
      idex_rs_q    <= id_rs;
      idex_rt_q    <= id_rt;
      idex_rd_q    <= id_rd;
    end
  end

  // Operand forwarding: MEM overrides WB overrides the register file; r0 never forwards.
  always_comb begin
    fwd_rs = idex_reg_a_q;
    if (idex_rs_q != 5'd0 && wb_reg_write && wb_rd == idex_rs_q)   fwd_rs = wb_result;
    if (idex_rs_q != 5'd0 && mem_reg_write && mem_rd == idex_rs_q) fwd_rs = mem_result;
    fwd_rt = idex_reg_b_q;
    if (idex_rt_q != 5'd0 && wb_reg_write && wb_rd == idex_rt_q)   fwd_rt = wb_result;
    if (idex_rt_q != 5'd0 && mem_reg_write && mem_rd == idex_rt_q) fwd_rt = mem_result;
    op_b = idex_use_imm_q ? idex_imm_q : fwd_rt;
  end

  assign sum   = fwd_rs + op_b;
  assign dif   = fwd_rs - op_b;
  assign shamt = idex_imm_q[10:6];

  // ALU; shifts take the forwarded rt, never the immediate path.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (idex_alu_op_q)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (fwd_rs[31] == op_b[31]) && (sum[31] != fwd_rs[31]);
      end
      ALU_ADDU: alu_res = sum;
      ALU_SUB: begin
        alu_res = dif;
        alu_ovf = (fwd_rs[31] != op_b[31]) && (dif[31] != fwd_rs[31]);
      end
      ALU_SUBU: alu_res = dif;
      ALU_AND:  alu_res = fwd_rs & op_b;
      ALU_OR:   alu_res = fwd_rs | op_b;
      ALU_XOR:  alu_res = fwd_rs ^ op_b;
      ALU_NOR:  alu_res = ~(fwd_rs | op_b);
      ALU_SLT:  alu_res = {31'd0, $signed(fwd_rs) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, fwd_rs < op_b};
      ALU_SLL:  alu_res = fwd_rt << shamt;
      ALU_SRL:  alu_res = fwd_rt >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(fwd_rt) >>> shamt);
      ALU_LUI:  alu_res = {idex_imm_q[15:0], 16'd0};
      default:  alu_res = '0;
    endcase
  end

  // The front end is held from the cycle a mul/div reaches EX until it is DONE.
  assign md_slot  = idex_valid_q && is_muldiv(idex_md_op_q);
  assign stall    = md_slot && !md_done;
  assign md_start = md_slot && !md_busy && !md_done;

  mul_div_unit u_mul_div (
    .clock   (clock),
    .reset_n (reset_n),
    .start_i (md_start),
    .op_i    (idex_md_op_q),
    .a_i     (fwd_rs),
    .b_i     (fwd_rt),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  // EX/MEM next value: bubbles while stalled, a write-less slot for a finished mul/div.
  always_comb begin
    exm_d = EXM_RST;
    if (idex_valid_q && !stall) begin
      exm_d.valid = 1'b1;
      if (!md_slot) begin
        exm_d.rd         = idex_dest_rt_q ? idex_rt_q : idex_rd_q;
        exm_d.store_data = fwd_rt;
        if (idex_md_op_q == MD_MFHI || idex_md_op_q == MD_MFLO) begin
          exm_d.result    = (idex_md_op_q == MD_MFHI) ? hi : lo;
          exm_d.reg_write = 1'b1;
        end else begin
          exm_d.result    = alu_res;
          exm_d.overflow  = alu_ovf;
          exm_d.reg_write = idex_reg_write_q && !alu_ovf;
          exm_d.mem_read  = idex_mem_read_q;
          exm_d.mem_write = idex_mem_write_q;
        end
      end
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) exm_q <= EXM_RST;
    else          exm_q <= exm_d;
  end

  assign exm_valid      = exm_q.valid;
  assign exm_reg_write  = exm_q.reg_write;
  assign exm_mem_read   = exm_q.mem_read;
  assign exm_mem_write  = exm_q.mem_write;
  assign exm_overflow   = exm_q.overflow;
  assign exm_result     = exm_q.result;
  assign exm_store_data = exm_q.store_data;
  assign exm_rd         = exm_q.rd;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus randomized instructions checked
// against an arithmetic reference model of forwarding, ALU and HI/LO.
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_valid, id_use_imm, id_dest_rt, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_reg_a, id_reg_b, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_md_op;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        stall, exm_valid, exm_reg_write, exm_mem_read, exm_mem_write, exm_overflow;
  logic [31:0] exm_result, exm_store_data;
  logic [4:0]  exm_rd;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_stage dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .id_valid       (id_valid),
    .id_reg_a       (id_reg_a),
    .id_reg_b       (id_reg_b),
    .id_imm         (id_imm),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_alu_op      (id_alu_op),
    .id_md_op       (id_md_op),
    .id_use_imm     (id_use_imm),
    .id_dest_rt     (id_dest_rt),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .mem_reg_write  (mem_reg_write),
    .wb_reg_write   (wb_reg_write),
    .mem_rd         (mem_rd),
    .wb_rd          (wb_rd),
    .mem_result     (mem_result),
    .wb_result      (wb_result),
    .stall          (stall),
    .exm_valid      (exm_valid),
    .exm_reg_write  (exm_reg_write),
    .exm_mem_read   (exm_mem_read),
    .exm_mem_write  (exm_mem_write),
    .exm_overflow   (exm_overflow),
    .exm_result     (exm_result),
    .exm_store_data (exm_store_data),
    .exm_rd         (exm_rd)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r != 5'd0 && mem_reg_write && mem_rd == r) return mem_result;
    if (r != 5'd0 && wb_reg_write && wb_rd == r)   return wb_result;
    return rf;
  endfunction

  task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rt, input logic [31:0] imm,
                         output logic [31:0] r, output logic ovf);
    longint sa, sb, s;
    int     srt;
    int     sh;
    sa  = $signed(a);
    sb  = $signed(b);
    srt = rt;
    sh  = int'(imm[10:6]);
    ovf = 1'b0;
    r   = 32'd0;
    case (op)
      4'd0, 4'd1: begin
        s = sa + sb; r = s[31:0];
        ovf = (op == 4'd0) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'd2, 4'd3: begin
        s = sa - sb; r = s[31:0];
        ovf = (op == 4'd2) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a | b);
      4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = rt << sh;
      4'd11: r = rt >> sh;
      4'd12: r = srt >>> sh;
      4'd13: r = imm * 32'd65536;
      default: r = 32'd0;
    endcase
  endtask

  task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, rm;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a); sb = $signed(b);
    ua = a; ub = b;
    if (op == 3'd1) begin
      p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0];
    end else if (op == 3'd2) begin
      p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0];
    end else if (b == 32'd0) begin
      m_lo = 32'hFFFF_FFFF; m_hi = a;
    end else if (op == 3'd3) begin
      q = sa / sb; rm = sa % sb; m_lo = q[31:0]; m_hi = rm[31:0];
    end else begin
      p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    id_valid = 1'b1; id_use_imm = 1'b0; id_dest_rt = 1'b0; id_reg_write = 1'b1;
    id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_reg_a = 32'd0; id_reg_b = 32'd0; id_imm = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_alu_op = 4'd0; id_md_op = 3'd0;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0; mem_rd = 5'd0; wb_rd = 5'd0;
    mem_result = 32'd0; wb_result = 32'd0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom % 64) - 32'd32;
      default: return $urandom;
    endcase
  endfunction

  // Single-cycle instruction: predict, issue for one cycle, follow with a bubble, check EX/MEM.
  task automatic run_alu(input string tag);
    logic [31:0] a, rt, b, r, e_res;
    logic        ovf, e_valid, e_we, e_mr, e_mw, e_ovf, is_mf;
    logic [4:0]  e_rd;
    a  = ref_fwd(id_rs, id_reg_a);
    rt = ref_fwd(id_rt, id_reg_b);
    b  = id_use_imm ? id_imm : rt;
    ref_alu(id_alu_op, a, b, rt, id_imm, r, ovf);
    is_mf   = (id_md_op == 3'd5) || (id_md_op == 3'd6);
    e_valid = id_valid;
    e_rd    = id_dest_rt ? id_rt : id_rd;
    if (!id_valid) begin
      e_res = 32'd0; e_we = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_ovf = 1'b0;
    end else if (is_mf) begin
      e_res = (id_md_op == 3'd5) ? m_hi : m_lo;
      e_we = 1'b1; e_mr = 1'b0; e_mw = 1'b0; e_ovf = 1'b0;
    end else begin
      e_res = r; e_ovf = ovf; e_we = id_reg_write && !ovf; e_mr = id_mem_read; e_mw = id_mem_write;
    end
    @(posedge clock); @(negedge clock);
    chk({tag, ".stall"}, stall, 1'b0);
    id_valid = 1'b0;
    @(posedge clock); @(negedge clock);
    chk({tag, ".valid"}, exm_valid, e_valid);
    chk({tag, ".we"}, exm_reg_write, e_we);
    chk({tag, ".mr"}, exm_mem_read, e_mr);
    chk({tag, ".mw"}, exm_mem_write, e_mw);
    chk({tag, ".ovf"}, exm_overflow, e_ovf);
    if (e_valid) begin
      chk({tag, ".res"}, exm_result, e_res);
      chk({tag, ".rd"}, exm_rd, e_rd);
      if (!is_mf) chk({tag, ".sd"}, exm_store_data, rt);
    end
  endtask

  // mul/div: predict HI/LO, measure the stall run, then check the bubble it leaves.
  task automatic run_md(input string tag);
    int n;
    ref_md(id_md_op, ref_fwd(id_rs, id_reg_a), ref_fwd(id_rt, id_reg_b));
    @(posedge clock);
    n = 0;
    @(negedge clock);
    while (stall && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk({tag, ".stall_len"}, n, 33);
    id_valid = 1'b0;
    @(posedge clock); @(negedge clock);
    chk({tag, ".bub_valid"}, exm_valid, 1'b1);
    chk({tag, ".bub_we"}, exm_reg_write, 1'b0);
    chk({tag, ".bub_mem"}, {exm_mem_read, exm_mem_write}, 2'b00);
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo);
    clr(); id_md_op = 3'd5; id_rd = 5'd9;
    run_alu({tag, ".mfhi"});
    chk({tag, ".hi"}, exm_result, e_hi);
    clr(); id_md_op = 3'd6; id_rd = 5'd10;
    run_alu({tag, ".mflo"});
    chk({tag, ".lo"}, exm_result, e_lo);
  endtask

  task automatic rand_instr();
    logic [15:0] i16;
    clr();
    id_valid     = ($urandom % 8) != 0;
    id_rs        = 5'($urandom % 4);
    id_rt        = 5'($urandom % 4);
    id_rd        = 5'($urandom);
    id_reg_a     = pick();
    id_reg_b     = pick();
    i16          = 16'($urandom);
    id_imm       = ($urandom % 2) ? {{16{i16[15]}}, i16} : pick();
    id_alu_op    = 4'($urandom);
    id_md_op     = (($urandom % 10) == 0) ? 3'(5 + $urandom % 2) : 3'd0;
    id_use_imm   = 1'($urandom);
    id_dest_rt   = 1'($urandom);
    id_reg_write = 1'($urandom);
    id_mem_read  = 1'($urandom);
    id_mem_write = 1'($urandom);
    mem_reg_write = 1'($urandom); mem_rd = 5'($urandom % 4); mem_result = pick();
    wb_reg_write  = 1'($urandom); wb_rd  = 5'($urandom % 4); wb_result  = pick();
  endtask

  initial begin
    clr();
    id_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset.valid", exm_valid, 1'b0);
    chk("reset.stall", stall, 1'b0);
    chk("reset.res", exm_result, 32'd0);
    chk("reset.en", {exm_reg_write, exm_mem_read, exm_mem_write, exm_overflow}, 4'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // forwarding priority
    clr(); id_rs = 5'd5; id_rt = 5'd3; id_reg_a = 32'd1; id_reg_b = 32'd3;
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'd10;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'd20;
    run_alu("fwd_prio");
    chk("fwd_prio.13", exm_result, 32'd13);
    clr(); id_rs = 5'd0; id_rt = 5'd3; id_reg_b = 32'd3;
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'd10;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'd20;
    run_alu("fwd_r0");
    chk("fwd_r0.3", exm_result, 32'd3);

    // overflow
    clr(); id_rs = 5'd1; id_reg_a = 32'h7FFF_FFFF; id_use_imm = 1'b1; id_imm = 32'd1;
    run_alu("add_ovf");
    chk("add_ovf.flag", exm_overflow, 1'b1);
    chk("add_ovf.we", exm_reg_write, 1'b0);
    clr(); id_rs = 5'd1; id_reg_a = 32'h7FFF_FFFF; id_use_imm = 1'b1; id_imm = 32'd1; id_alu_op = 4'd1;
    run_alu("addu");
    chk("addu.res", exm_result, 32'h8000_0000);
    chk("addu.we", exm_reg_write, 1'b1);

    // mult -3 x 7
    clr(); id_md_op = 3'd1; id_rs = 5'd1; id_rt = 5'd2; id_reg_a = 32'hFFFF_FFFD; id_reg_b = 32'd7;
    run_md("mult");
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // div 7 / -2 and divu by zero
    clr(); id_md_op = 3'd3; id_rs = 5'd1; id_rt = 5'd2; id_reg_a = 32'd7; id_reg_b = 32'hFFFF_FFFE;
    run_md("div");
    check_hilo("div", 32'd1, 32'hFFFF_FFFD);
    clr(); id_md_op = 3'd4; id_rs = 5'd1; id_rt = 5'd2; id_reg_a = 32'd100; id_reg_b = 32'd0;
    run_md("divu0");
    check_hilo("divu0", 32'd100, 32'hFFFF_FFFF);

    // reset in the middle of a divide (count 15)
    clr(); id_md_op = 3'd3; id_rs = 5'd1; id_rt = 5'd2; id_reg_a = 32'd1000; id_reg_b = 32'd3;
    repeat (17) @(posedge clock);
    #2;
    chk("rst_mid.stall_before", stall, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.stall", stall, 1'b0);
    chk("rst_mid.valid", exm_valid, 1'b0);
    chk("rst_mid.res", exm_result, 32'd0);
    id_valid = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clock);
    reset_n = 1'b1;
    clr(); id_rt = 5'd1; id_dest_rt = 1'b1; id_use_imm = 1'b1; id_imm = 32'd5;
    run_alu("addi");
    chk("addi.res", exm_result, 32'd5);
    chk("addi.rd", exm_rd, 5'd1);
    check_hilo("rst_hilo", 32'd0, 32'd0);

    // bubble, sra, sltu
    clr(); id_valid = 1'b0; id_mem_read = 1'b1; id_mem_write = 1'b1;
    run_alu("bubble");
    chk("bubble.en", {exm_valid, exm_reg_write, exm_mem_read, exm_mem_write}, 4'd0);
    clr(); id_alu_op = 4'd12; id_rt = 5'd2; id_reg_b = 32'h8000_0000; id_imm = 32'h0000_0100;
    run_alu("sra");
    chk("sra.res", exm_result, 32'hF800_0000);
    clr(); id_alu_op = 4'd9; id_rs = 5'd1; id_rt = 5'd2; id_reg_a = 32'd1; id_reg_b = 32'hFFFF_FFFF;
    run_alu("sltu");
    chk("sltu.res", exm_result, 32'd1);

    // randomized single-cycle traffic
    for (int i = 0; i < 300; i++) begin
      rand_instr();
      run_alu("rnd_alu");
    end

    // randomized multiply/divide
    for (int i = 0; i < 12; i++) begin
      rand_instr();
      id_valid = 1'b1;
      id_md_op = 3'(1 + $urandom % 4);
      if ($urandom % 4 == 0) id_reg_b = 32'd0;
      if (id_rt != 5'd0 && ((mem_reg_write && mem_rd == id_rt) || (wb_reg_write && wb_rd == id_rt))
          && ($urandom % 2 == 0)) begin
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      end
      run_md("rnd_md");
      check_hilo("rnd_md", m_hi, m_lo);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of instruction decode. It holds the ID/EX pipeline register and resolves operands through MEM/WB forwarding. It computes ALU results and drives the EX/MEM pipeline register. It also owns the HI/LO registers and an iterative multiply/divide unit, which stalls the front of the pipeline (PC, IF/ID, ID) while it runs.

## Interface
- No parameters; data width fixed at 32.
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID slot holds a real instruction; 0 = bubble from hazard unit
- id_reg_a, id_reg_b  in  32  register-file read values
- id_imm  in  32  sign-extended immediate; [10:6] is shamt
- id_rs, id_rt, id_rd  in  5  source/destination specifiers
- id_alu_op  in  4  ALU operation code
- id_md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo
- id_use_imm, id_dest_rt, id_reg_write, id_mem_read, id_mem_write  in  1  decoded control
- mem_reg_write, wb_reg_write  in  1  forwarding-source write enables
- mem_rd, wb_rd  in  5  forwarding-source destinations
- mem_result, wb_result  in  32  forwarding-source data
- stall  out  1  freeze PC, IF/ID and ID/EX inputs
- exm_valid, exm_reg_write, exm_mem_read, exm_mem_write, exm_overflow  out  1  EX/MEM control
- exm_result, exm_store_data  out  32  ALU/HI/LO result; forwarded rt for stores
- exm_rd  out  5  final destination, rt when dest_rt else rd

## Operation
- ID/EX register loads at each edge when stall=0 and holds when stall=1.
- Forwarding runs separately for rs and rt. MEM source has priority over WB; WB over register file.
- A source is forwarded only when its write enable is 1 and its destination equals the operand specifier and is nonzero. Register 0 is never forwarded.
- Load-use hazards are the upstream hazard unit's job; this block does not detect them.
- Operand B = id_imm when use_imm=1, else forwarded rt.
- ALU codes: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt (signed), 9 sltu, 10 sll, 11 srl, 12 sra, 13 lui (imm<<16). Codes 14-15 produce 0.
- Shifts use shamt = imm[10:6] and shift forwarded rt.
- add/sub signed overflow sets exm_overflow=1 and forces exm_reg_write=0. addu/subu never overflow.
- mfhi/mflo: exm_result = HI/LO and exm_reg_write=1.
- Multiply/divide FSM, states IDLE → RUN → DONE → IDLE:
  - IDLE with mult/div in ID/EX: stall=1. Next edge latches forwarded operand magnitudes and sign info, clears the count, and goes to RUN.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle, count 0..31, stall=1. At count=31 the edge writes HI/LO and enters DONE.
  - DONE: stall=0. The mult/div leaves as a bubble into EX/MEM (exm_valid=1, all write/mem enables 0). Next edge returns to IDLE.
- Signed ops negate the result when operand signs differ. Remainder takes the dividend's sign: 7/−2 → LO=−3, HI=1.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend. No stall extension.
- An id_valid=0 slot propagates as exm_valid=0 with every enable 0.

## Timing
- Single-cycle ops: instruction in ID/EX during cycle t, EX/MEM outputs valid in cycle t+1.
- mult/div: stall high for 33 consecutive cycles (t..t+32), low in DONE (t+33). A following mfhi sees the new HI with no further stall.
- stall is combinational from the ID/EX contents and FSM state.
- Reset (asynchronous, any time, including mid-RUN):
  - all exm_* outputs = 0
  - ID/EX register cleared to a bubble
  - HI = LO = 0, FSM = IDLE, stall = 0
  - an in-flight operation is discarded.
- Same destination written by both MEM and WB sources: MEM value wins.

## Structure
- Shared package: ALU op codes, md op codes, reset values of the EX/MEM fields.
- Sub-module mul_div_unit contains the FSM, 5-bit counter, the remainder/accumulator and quotient/multiplier working registers, and HI/LO, with start/busy/done handshake.
- ex_stage contains the ID/EX register, forwarding muxes, ALU and EX/MEM register.

## Test plan
- Forward priority: rs=5 with mem_rd=5 (mem_result=10) and wb_rd=5 (wb_result=20), add with rt=3 → exm_result=13. Repeat with rs=0 → no forwarding.
- Overflow: add 32'h7FFFFFFF + 1 → exm_overflow=1, exm_reg_write=0. addu of the same → 32'h80000000, write enabled.
- mult −3 × 7 → stall high exactly 33 cycles; HI=FFFFFFFF, LO=FFFFFFEB; following mfhi/mflo return them with no stall.
- div 7 / −2 → LO=FFFFFFFD, HI=00000001. divu 100/0 → LO=FFFFFFFF, HI=100.
- Reset asserted at count=15 of a divide → stall=0, HI=LO=0, exm_valid=0 immediately; after release, addi r1 = 0+5 gives exm_result=5.
- Bubble and shifts: id_valid=0 → all exm enables 0. sra of 32'h80000000 by 4 → F8000000. sltu 1 < FFFFFFFF → 1.
